// File: rtl/ws2812_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ws2812_chain_ctrl
//  Purpose  : Streams NUM_LEDS 24-bit pixels to a WS2812 chain. Pixels are
//             fetched over a req/valid handshake with one-pixel prefetch,
//             then serialised as fixed-period pulse-width bits and followed
//             by a low latch period.
//  Revision : 1.0 - initial release
// ============================================================================
module ws2812_chain_ctrl #(
    parameter int NUM_LEDS = 8,
    parameter int T0H      = 20,
    parameter int T1H      = 40,
    parameter int TBIT     = 63,
    parameter int TLATCH   = 2500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        pix_req,
    output logic [7:0]  pix_idx,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic        led_data_out
);

    localparam int            CW           = $clog2(TBIT + 1);
    localparam logic [CW-1:0] C_BIT_LAST   = CW'(TBIT - 1);
    localparam logic [CW-1:0] C_T0H        = CW'(T0H);
    localparam logic [CW-1:0] C_T1H        = CW'(T1H);
    localparam logic [11:0]   C_LATCH_LAST = 12'(TLATCH - 1);
    localparam logic [7:0]    C_LAST_PIX   = 8'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;          // cycle within current bit period
    logic [4:0]    bit_q, bit_d;          // bit index, 23 down to 0
    logic [7:0]    pix_q, pix_d;          // pixel currently on the line
    logic [7:0]    idx_q, idx_d;          // pixel index being requested
    logic [11:0]   lat_q, lat_d;          // latch period counter
    logic [23:0]   sh_q, sh_d;            // serialiser, MSB is the live bit
    logic [23:0]   buf_q, buf_d;          // prefetched next pixel
    logic          buf_full_q, buf_full_d;
    logic          req_q, req_d;
    logic          done_q, done_d;
    logic          unr_q, unr_d;
    logic          led_q, led_d;
    logic          capture;

    // A pixel is taken only while a request is outstanding.
    assign capture = req_q && pix_valid;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            bit_q      <= '0;
            pix_q      <= '0;
            idx_q      <= '0;
            lat_q      <= '0;
            sh_q       <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            unr_q      <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            pix_q      <= pix_d;
            idx_q      <= idx_d;
            lat_q      <= lat_d;
            sh_q       <= sh_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            req_q      <= req_d;
            done_q     <= done_d;
            unr_q      <= unr_d;
            led_q      <= led_d;
        end
    end

    // Next-state logic: frame sequencing, handshake, prefetch and bit timing.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        pix_d      = pix_q;
        idx_d      = idx_q;
        lat_d      = lat_q;
        sh_d       = sh_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        req_d      = req_q;
        unr_d      = unr_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    req_d      = 1'b1;
                    idx_d      = 8'd0;
                    pix_d      = 8'd0;
                    buf_full_d = 1'b0;
                    unr_d      = 1'b0;
                end
            end

            S_FETCH: begin
                if (capture) begin
                    state_d = S_SEND;
                    sh_d    = pix_data;
                    req_d   = 1'b0;
                    cyc_d   = '0;
                    bit_d   = 5'd23;
                end
            end

            S_SEND: begin
                if (capture) begin
                    buf_d      = pix_data;
                    buf_full_d = 1'b1;
                    req_d      = 1'b0;
                end
                // Request the next pixel once the current one is under way.
                if ((cyc_q == '0) && (bit_q == 5'd23) && (pix_q < C_LAST_PIX)) begin
                    req_d = 1'b1;
                    idx_d = pix_q + 8'd1;
                end
                if (cyc_q != C_BIT_LAST) begin
                    cyc_d = cyc_q + CW'(1);
                end else begin
                    cyc_d = '0;
                    if (bit_q != 5'd0) begin
                        bit_d = bit_q - 5'd1;
                        sh_d  = {sh_q[22:0], 1'b0};
                    end else if (pix_q == C_LAST_PIX) begin
                        state_d = S_LATCH;
                        lat_d   = '0;
                    end else if (buf_full_q) begin
                        sh_d       = buf_q;
                        buf_full_d = 1'b0;
                        pix_d      = pix_q + 8'd1;
                        bit_d      = 5'd23;
                    end else if (capture) begin
                        // Pixel arrived in the very last cycle: use it directly.
                        sh_d       = pix_data;
                        buf_full_d = 1'b0;
                        pix_d      = pix_q + 8'd1;
                        bit_d      = 5'd23;
                    end else begin
                        state_d = S_WAIT;
                        unr_d   = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (capture) begin
                    state_d = S_SEND;
                    sh_d    = pix_data;
                    req_d   = 1'b0;
                    cyc_d   = '0;
                    bit_d   = 5'd23;
                    pix_d   = pix_q + 8'd1;
                end
            end

            S_LATCH: begin
                if (lat_q == C_LATCH_LAST) begin
                    state_d = S_IDLE;
                    lat_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    lat_d = lat_q + 12'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Registered line: high for the first T0H/T1H cycles of each bit.
        led_d = (state_d == S_SEND) && (cyc_d < (sh_d[23] ? C_T1H : C_T0H));
    end

    assign pix_req      = req_q;
    assign pix_idx      = idx_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign underrun     = unr_q;
    assign led_data_out = led_q;

endmodule
`default_nettype wire
